// File: rtl/pu_accum_seq_if.sv
// Host-side channels of the accumulate sequencer: job descriptor, operand stream, result.
// The master drives jobs/operands and consumes results; the slave is the sequencer.
interface pu_accum_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int MAX_TERMS  = 8,
  parameter int CNT_WIDTH  = 3
);
  logic                  job_valid;
  logic                  job_ready;
  logic [CNT_WIDTH-1:0]  job_terms;
  logic [MAX_TERMS-1:0]  job_neg_mask;

  logic                  opnd_valid;
  logic                  opnd_ready;
  logic [DATA_WIDTH-1:0] opnd_data;
  logic [ATTR_WIDTH-1:0] opnd_attr;

  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic [ATTR_WIDTH-1:0] res_attr;

  modport master (
    output job_valid, job_terms, job_neg_mask,
    output opnd_valid, opnd_data, opnd_attr,
    output res_ready,
    input  job_ready, opnd_ready, res_valid, res_data, res_attr
  );

  modport slave (
    input  job_valid, job_terms, job_neg_mask,
    input  opnd_valid, opnd_data, opnd_attr,
    input  res_ready,
    output job_ready, opnd_ready, res_valid, res_data, res_attr
  );
endinterface

// File: rtl/pu_accum_seq.sv
// Job sequencer for one pu_accum: streams a job's operands into the PU as init/load
// commands, pulses output-enable, captures the sum and returns it on the result port.
module pu_accum_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int MAX_TERMS  = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pu_accum_seq_if.slave         bus,
  output logic                  signal_init,
  output logic                  signal_load,
  output logic                  signal_neg,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] acc_data_in,
  output logic [ATTR_WIDTH-1:0] acc_attr_in,
  input  logic [DATA_WIDTH-1:0] acc_data_out,
  input  logic [ATTR_WIDTH-1:0] acc_attr_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_ACC,
    S_OE,
    S_CAPT,
    S_RESULT
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  terms_q, terms_d;
  logic [MAX_TERMS-1:0]  mask_q,  mask_d;
  logic [CNT_WIDTH-1:0]  idx_q,   idx_d;
  logic [DATA_WIDTH-1:0] res_data_q,  res_data_d;
  logic [ATTR_WIDTH-1:0] res_attr_q,  res_attr_d;
  logic                  res_valid_q, res_valid_d;

  logic job_ready_c;
  logic opnd_ready_c;
  logic load_c;
  logic init_c;
  logic neg_c;
  logic oe_c;

  // NOTE: always_comb assigns every output a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    terms_d      = terms_q;
    mask_d       = mask_q;
    idx_d        = idx_q;
    res_data_d   = res_data_q;
    res_attr_d   = res_attr_q;
    res_valid_d  = res_valid_q;
    job_ready_c  = 1'b0;
    opnd_ready_c = 1'b0;
    load_c       = 1'b0;
    init_c       = 1'b0;
    neg_c        = 1'b0;
    oe_c         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        job_ready_c = 1'b1;
        if (bus.job_valid) begin
          terms_d = bus.job_terms;
          mask_d  = bus.job_neg_mask;
          idx_d   = '0;
          state_d = S_FIRST;
        end
      end

      S_FIRST: begin
        opnd_ready_c = 1'b1;
        if (bus.opnd_valid) begin
          load_c = 1'b1;
          init_c = 1'b1;
          neg_c  = mask_q[0];
          if (terms_q == '0) begin
            state_d = S_OE;
          end else begin
            idx_d   = CNT_WIDTH'(1);
            state_d = S_ACC;
          end
        end
      end

      // A bubble (opnd_valid low) issues nothing and holds idx.
      S_ACC: begin
        opnd_ready_c = 1'b1;
        if (bus.opnd_valid) begin
          load_c = 1'b1;
          neg_c  = mask_q[idx_q];
          if (idx_q == terms_q) begin
            state_d = S_OE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_OE: begin
        oe_c    = 1'b1;
        state_d = S_CAPT;
      end

      // The PU presents its sum in the cycle after the output-enable pulse.
      S_CAPT: begin
        res_data_d  = acc_data_out;
        res_attr_d  = acc_attr_out;
        res_valid_d = 1'b1;
        state_d     = S_RESULT;
      end

      S_RESULT: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the result holding registers, is cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      terms_q     <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      res_data_q  <= '0;
      res_attr_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      terms_q     <= terms_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      res_data_q  <= res_data_d;
      res_attr_q  <= res_attr_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.job_ready  = job_ready_c;
  assign bus.opnd_ready = opnd_ready_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_attr   = res_attr_q;

  assign signal_load = load_c;
  assign signal_init = init_c;
  assign signal_neg  = neg_c;
  assign signal_oe   = oe_c;

  assign acc_data_in = bus.opnd_data;
  assign acc_attr_in = bus.opnd_attr;

endmodule

// File: tb/tb_pu_accum_seq.sv
// Randomized and directed bench for pu_accum_seq with a behavioural PU and an
// arithmetic reference model of whole jobs.
module tb_pu_accum_seq;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MT = 8;
  localparam int CW = 3;
  localparam int LOGN = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pu_accum_seq_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .MAX_TERMS(MT), .CNT_WIDTH(CW)) bus ();

  logic          sig_init, sig_load, sig_neg, sig_oe;
  logic [DW-1:0] acc_din;
  logic [AW-1:0] acc_ain;
  logic [DW-1:0] acc_dout = '0;
  logic [AW-1:0] acc_aout = '0;

  pu_accum_seq #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .MAX_TERMS(MT), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .signal_init  (sig_init),
    .signal_load  (sig_load),
    .signal_neg   (sig_neg),
    .signal_oe    (sig_oe),
    .acc_data_in  (acc_din),
    .acc_attr_in  (acc_ain),
    .acc_data_out (acc_dout),
    .acc_attr_out (acc_aout)
  );

  // Behavioural PU: attr bit0 = sticky unsigned carry on additions, upper bits = OR of operand attrs.
  // It is deliberately not reset so that a fresh job must rely on init.
  logic [DW-1:0] pu_acc  = '0;
  logic [AW-1:0] pu_attr = '0;
  always @(posedge clk) begin
    logic [DW-1:0] term, base;
    logic [DW:0]   sum;
    if (sig_load) begin
      term = sig_neg ? (~acc_din + 1'b1) : acc_din;
      base = sig_init ? '0 : pu_acc;
      sum  = {1'b0, base} + {1'b0, term};
      pu_acc <= sum[DW-1:0];
      pu_attr[AW-1:1] <= (sig_init ? '0 : pu_attr[AW-1:1]) | acc_ain[AW-1:1];
      pu_attr[0]      <= (sig_init ? 1'b0 : pu_attr[0]) | (sum[DW] & ~sig_neg & ~sig_init);
    end
    if (sig_oe) begin
      acc_dout <= pu_acc;
      acc_aout <= pu_attr;
    end
  end

  // Monitor sampled mid-cycle.
  int cyc = 0;
  int n_load = 0, n_init = 0, n_oe = 0, n_bad = 0, last_load_cyc = 0;
  logic          neg_log  [LOGN];
  logic [DW-1:0] data_log [LOGN];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst) begin
      if (sig_load) begin
        neg_log[n_load % LOGN]  = sig_neg;
        data_log[n_load % LOGN] = acc_din;
        n_load = n_load + 1;
        last_load_cyc = cyc;
      end
      if (sig_init) n_init = n_init + 1;
      if (sig_oe)   n_oe   = n_oe + 1;
      if ((sig_load && !(bus.opnd_valid && bus.opnd_ready)) ||
          (sig_init && !sig_load) || (sig_neg && !sig_load) ||
          (sig_oe && (sig_load || bus.opnd_ready)))
        n_bad = n_bad + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] job_d [MT];
  logic [AW-1:0] job_a [MT];

  // Reference: signed/modular sum of the first n terms; carry flagged on wrapping additions.
  function automatic void ref_job(input int n, input logic [MT-1:0] mask,
                                  output logic [DW-1:0] rd, output logic [AW-1:0] ra);
    longint unsigned modv = 64'd1 << DW;
    longint unsigned acc  = 0;
    bit ovf = 1'b0;
    logic [AW-1:1] flags = '0;
    for (int i = 0; i < n; i++) begin
      if (mask[i]) begin
        acc = (acc + modv - longint'(job_d[i])) % modv;
      end else begin
        if (i > 0 && acc + longint'(job_d[i]) >= modv) ovf = 1'b1;
        acc = (acc + longint'(job_d[i])) % modv;
      end
      flags |= job_a[i][AW-1:1];
    end
    rd = acc[DW-1:0];
    ra = {flags, ovf};
  endfunction

  task automatic send_opnd(input logic [DW-1:0] d, input logic [AW-1:0] a);
    int g = 0;
    bus.opnd_valid = 1'b1;
    bus.opnd_data  = d;
    bus.opnd_attr  = a;
    while (!bus.opnd_ready && g < 20) begin
      tick();
      g++;
    end
    if (g >= 20) check("opnd_ready_timeout", 0, 1);
    tick();
    bus.opnd_valid = 1'b0;
    bus.opnd_data  = $urandom;
  endtask

  // bub >= 0: fixed bubble count between operands; bub < 0: random 0..2.
  task automatic run_job(input string tag, input int n, input logic [MT-1:0] mask,
                         input int bub, input int hold);
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    logic [MT-1:0] neg_seen, neg_exp;
    int l0, i0, o0, b0, g, unstable, data_bad;
    ref_job(n, mask, ed, ea);
    l0 = n_load; i0 = n_init; o0 = n_oe; b0 = n_bad;

    check({tag, "_job_ready_idle"}, bus.job_ready, 1);
    bus.job_valid    = 1'b1;
    bus.job_terms    = CW'(n - 1);
    bus.job_neg_mask = mask;
    tick();
    bus.job_valid    = 1'b0;
    bus.job_terms    = CW'($urandom);
    bus.job_neg_mask = MT'($urandom);
    check({tag, "_job_ready_busy"}, bus.job_ready, 0);

    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ((bub >= 0) ? bub : $urandom_range(2, 0)) tick();
      send_opnd(job_d[i], job_a[i]);
    end

    g = 0;
    while (!bus.res_valid && g < 40) begin
      tick();
      g++;
    end
    check({tag, "_res_valid_seen"}, g < 40, 1);
    check({tag, "_latency"}, cyc - last_load_cyc, 3);
    check({tag, "_res_data"}, bus.res_data, ed);
    check({tag, "_res_attr"}, bus.res_attr, ea);

    // Backpressure: stray job/operand requests must be ignored while the result waits.
    unstable = 0;
    bus.res_ready = 1'b0;
    repeat (hold) begin
      bus.opnd_valid = 1'b1;
      tick();
      if (!bus.res_valid || bus.res_data !== ed || bus.job_ready || bus.opnd_ready)
        unstable++;
    end
    bus.opnd_valid = 1'b0;
    check({tag, "_hold_stable"}, unstable, 0);

    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_res_valid_clr"}, bus.res_valid, 0);
    check({tag, "_job_ready_back"}, bus.job_ready, 1);

    check({tag, "_loads"}, n_load - l0, n);
    check({tag, "_inits"}, n_init - i0, 1);
    check({tag, "_oe_pulses"}, n_oe - o0, 1);
    check({tag, "_illegal_cmds"}, n_bad - b0, 0);
    neg_seen = '0;
    neg_exp  = '0;
    data_bad = 0;
    for (int i = 0; i < n && i < n_load - l0; i++) begin
      neg_seen[i] = neg_log[(l0 + i) % LOGN];
      neg_exp[i]  = mask[i];
      if (data_log[(l0 + i) % LOGN] !== job_d[i]) data_bad++;
    end
    check({tag, "_neg_seq"}, neg_seen, neg_exp);
    check({tag, "_data_pass"}, data_bad, 0);
  endtask

  initial begin
    bus.job_valid = 1'b0; bus.job_terms = '0; bus.job_neg_mask = '0;
    bus.opnd_valid = 1'b0; bus.opnd_data = '0; bus.opnd_attr = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < MT; i++) begin
      job_d[i] = '0;
      job_a[i] = '0;
    end

    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_job_ready", bus.job_ready, 1);
    check("rst_opnd_ready", bus.opnd_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_cmds", {sig_init, sig_load, sig_neg, sig_oe}, 4'b0000);
    rst = 1'b1;
    tick();

    // Three terms 5 - 3 + 2.
    job_d[0] = 5; job_d[1] = 3; job_d[2] = 2;
    job_a[0] = 0; job_a[1] = 0; job_a[2] = 0;
    run_job("three", 3, 8'b0000_0010, 0, 0);

    // Single negated term.
    job_d[0] = 7;
    run_job("single_neg", 1, 8'b0000_0001, 0, 0);

    // Four ones with three-cycle bubbles.
    for (int i = 0; i < 4; i++) job_d[i] = 1;
    run_job("bubbles", 4, 8'b0000_0000, 3, 0);

    // Result backpressure for five cycles.
    job_d[0] = 32'h1234_5678; job_d[1] = 32'h0000_1111;
    run_job("backpressure", 2, 8'b0000_0000, 0, 5);

    // Carry out of the top bit plus attribute pass-through.
    job_d[0] = 32'hFFFF_FFF7; job_d[1] = 9;
    job_a[0] = 4'b1010;       job_a[1] = 4'b0100;
    run_job("overflow", 2, 8'b0000_0000, 0, 1);
    job_a[0] = 0; job_a[1] = 0;

    // Mask bits above the term count must be ignored.
    job_d[0] = 40; job_d[1] = 2;
    run_job("mask_high", 2, 8'b1111_1100, 0, 0);

    // Full-length job.
    for (int i = 0; i < MT; i++) job_d[i] = 32'(i * 10 + 1);
    run_job("max_terms", MT, 8'b1010_0101, 0, 0);

    // Reset in the middle of a 4-term job, with an operand being offered.
    bus.job_valid = 1'b1; bus.job_terms = 3; bus.job_neg_mask = 8'hFF;
    tick();
    bus.job_valid = 1'b0;
    send_opnd(100, 4'b1110);
    send_opnd(200, 4'b1110);
    bus.opnd_valid = 1'b1;
    bus.opnd_data  = 300;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_cmds", {sig_init, sig_load, sig_neg, sig_oe}, 4'b0000);
    check("midrst_job_ready", bus.job_ready, 1);
    check("midrst_opnd_ready", bus.opnd_ready, 0);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_res", {bus.res_attr, bus.res_data}, 0);
    bus.opnd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    job_d[0] = 6; job_d[1] = 1;
    job_a[0] = 0; job_a[1] = 0;
    run_job("after_rst", 2, 8'b0000_0000, 0, 0);

    // Random jobs.
    for (int j = 0; j < 40; j++) begin
      int n;
      n = $urandom_range(MT, 1);
      for (int i = 0; i < MT; i++) begin
        job_d[i] = ($urandom_range(3, 0) == 0) ? DW'($urandom_range(15, 0)) : DW'($urandom);
        job_a[i] = AW'($urandom);
      end
      run_job($sformatf("rand%0d", j), n, MT'($urandom), -1, $urandom_range(3, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
